full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 14 +
 rtl/full_adder_bit.sv | 15 +
 rtl/full_adder.sv | 56 +++++
 tb/tb_full_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared helpers for the bit-sliced full adder: per-bit sum/carry equations and build limits.
package full_adder_pkg;

  localparam int unsigned MaxLatency = 1;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One combinational full-adder cell (3:2 compressor).
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = fa_sum(a, b, c);
  assign carry = fa_carry(a, b, c);

endmodule

// File: rtl/full_adder.sv
// WIDTH independent full-adder slices with an optional reset-to-zero output register.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] c_out,
  input  logic [WIDTH-1:0] in_c
);

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] carry_comb;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_slice
    full_adder_bit u_bit (
      .a     (in_a[i]),
      .b     (in_b[i]),
      .c     (in_c[i]),
      .sum   (sum_comb[i]),
      .carry (carry_comb[i])
    );
  end

  if (LATENCY == 0) begin : gen_comb
    assign sum_out = sum_comb;
    assign c_out   = carry_comb;
    // clk/rst exist only so both builds share one port list.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else if (LATENCY == MaxLatency) begin : gen_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= '0;
      end else begin
        sum_q   <= sum_comb;
        carry_q <= carry_comb;
      end
    end

    assign sum_out = sum_q;
    assign c_out   = carry_q;
  end else begin : gen_bad_latency
    $error("full_adder: LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: truth table, 8-bit ripple chain, slice independence, registered build.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: per slice, count the ones; sum is the parity, carry is count >= 2.
  function automatic logic [7:0] ref_sum(input logic [7:0] a, b, c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [7:0] ref_carry(input logic [7:0] a, b, c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  // Single-slice combinational instance
  logic w1_a, w1_b, w1_c, w1_sum, w1_co;
  full_adder #(.WIDTH(1), .LATENCY(0)) u_w1 (
    .clk(clk), .rst(rst), .in_a(w1_a), .in_b(w1_b),
    .sum_out(w1_sum), .c_out(w1_co), .in_c(w1_c)
  );

  // 8-cell ripple chain
  logic [7:0] rc_a, rc_b, rc_sum, rc_co;
  logic       rc_cin;
  logic [8:0] rc_carry;
  assign rc_carry[0] = rc_cin;
  for (genvar i = 0; i < 8; i++) begin : gen_ripple
    full_adder #(.WIDTH(1), .LATENCY(0)) u_rc (
      .clk(clk), .rst(rst), .in_a(rc_a[i]), .in_b(rc_b[i]),
      .sum_out(rc_sum[i]), .c_out(rc_co[i]), .in_c(rc_carry[i])
    );
    assign rc_carry[i+1] = rc_co[i];
  end

  // Four independent combinational slices
  logic [3:0] w4_a, w4_b, w4_c, w4_sum, w4_co;
  full_adder #(.WIDTH(4), .LATENCY(0)) u_w4 (
    .clk(clk), .rst(rst), .in_a(w4_a), .in_b(w4_b),
    .sum_out(w4_sum), .c_out(w4_co), .in_c(w4_c)
  );

  // Four registered slices
  logic [3:0] p_a, p_b, p_c, p_sum, p_co;
  full_adder #(.WIDTH(4), .LATENCY(1)) u_p (
    .clk(clk), .rst(rst), .in_a(p_a), .in_b(p_b),
    .sum_out(p_sum), .c_out(p_co), .in_c(p_c)
  );

  typedef struct {
    logic a, b, c;
    logic s, co;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] ea, eb, ec, es, eco;
    logic [8:0] total;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    w1_a = 0; w1_b = 0; w1_c = 0;
    rc_a = 0; rc_b = 0; rc_cin = 0;
    w4_a = 0; w4_b = 0; w4_c = 0;
    p_a = 4'hF; p_b = 4'h0; p_c = 4'h0;

    // Reset state of the registered build, before any clock edge
    #1;
    check("reset_sum", {12'd0, p_sum}, 16'h0);
    check("reset_cout", {12'd0, p_co}, 16'h0);

    // Truth table, single slice (rst still high: combinational build ignores it)
    foreach (tbl[i]) begin
      w1_a = tbl[i].a; w1_b = tbl[i].b; w1_c = tbl[i].c;
      #1;
      check($sformatf("tt_sum_%0d", i), {15'd0, w1_sum}, {15'd0, tbl[i].s});
      check($sformatf("tt_cout_%0d", i), {15'd0, w1_co}, {15'd0, tbl[i].co});
    end

    // Ripple corner cases with overflow = c7 ^ c6
    rc_a = 8'h7F; rc_b = 8'h01; rc_cin = 0; #1;
    check("rip_7f_sum", {8'd0, rc_sum}, 16'h0080);
    check("rip_7f_cout", {15'd0, rc_co[7]}, 16'h0);
    check("rip_7f_ovf", {15'd0, rc_co[7] ^ rc_co[6]}, 16'h1);
    rc_a = 8'hFF; rc_b = 8'h01; rc_cin = 0; #1;
    check("rip_ff_sum", {8'd0, rc_sum}, 16'h0000);
    check("rip_ff_cout", {15'd0, rc_co[7]}, 16'h1);
    check("rip_ff_ovf", {15'd0, rc_co[7] ^ rc_co[6]}, 16'h0);

    // Random ripple additions against plain arithmetic
    for (int n = 0; n < 40; n++) begin
      rc_a = 8'($urandom); rc_b = 8'($urandom); rc_cin = 1'($urandom);
      #1;
      total = 9'(rc_a) + 9'(rc_b) + 9'(rc_cin);
      check("rip_rand", {7'd0, rc_co[7], rc_sum}, {7'd0, total});
    end

    // Slice independence
    w4_a = 4'b1100; w4_b = 4'b1010; w4_c = 4'b0110; #1;
    check("w4_sum", {12'd0, w4_sum}, 16'h0);
    check("w4_cout", {12'd0, w4_co}, 16'h000E);
    for (int n = 0; n < 40; n++) begin
      w4_a = 4'($urandom); w4_b = 4'($urandom); w4_c = 4'($urandom);
      #1;
      ea = {4'd0, w4_a}; eb = {4'd0, w4_b}; ec = {4'd0, w4_c};
      check("w4_rand", {4'd0, w4_co, 4'd0, w4_sum},
            {ref_carry(ea, eb, ec), ref_sum(ea, eb, ec)});
    end

    // Registered build: release reset mid-cycle, then first result on the next edge
    @(negedge clk);
    check("rst_hold_sum", {12'd0, p_sum}, 16'h0);
    rst = 0; #1;
    check("rel_no_edge", {12'd0, p_sum}, 16'h0);
    @(posedge clk); #1;
    check("first_after_rel", {12'd0, p_co, p_sum}, 16'h000F);

    // Latency: new inputs not visible before the edge, visible after it
    @(negedge clk);
    p_a = 4'b0001; p_b = 4'b0001; p_c = 4'b0000; #1;
    check("lat_before", {8'd0, p_co, p_sum}, 16'h000F);
    @(posedge clk); #1;
    check("lat_after", {8'd0, p_co, p_sum}, 16'h0010);

    // Async reset while outputs are 1: drop at once, hold through an edge
    @(negedge clk);
    p_a = 4'hF; p_b = 4'h0; p_c = 4'h0;
    @(posedge clk); #1;
    check("pre_rst_ones", {8'd0, p_co, p_sum}, 16'h000F);
    #2 rst = 1; #1;
    check("async_rst", {8'd0, p_co, p_sum}, 16'h0);
    @(posedge clk); #1;
    check("rst_hold_edge", {8'd0, p_co, p_sum}, 16'h0);
    @(negedge clk); rst = 0; #1;
    check("rst_rel_wait", {8'd0, p_co, p_sum}, 16'h0);
    @(posedge clk); #1;
    check("rst_rel_edge", {8'd0, p_co, p_sum}, 16'h000F);

    // Random registered stream, one-cycle delayed reference
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      p_a = 4'($urandom); p_b = 4'($urandom); p_c = 4'($urandom);
      ea = {4'd0, p_a}; eb = {4'd0, p_b}; ec = {4'd0, p_c};
      es = ref_sum(ea, eb, ec); eco = ref_carry(ea, eb, ec);
      @(posedge clk); #1;
      check("pipe_rand", {4'd0, p_co, 4'd0, p_sum}, {eco, es});
    end

    // Combinational build with rst toggling and clk running
    for (int n = 0; n < 16; n++) begin
      rst = ~rst;
      w1_a = tbl[n % 8].a; w1_b = tbl[n % 8].b; w1_c = tbl[n % 8].c;
      #3;
      check("rst_ignored", {14'd0, w1_co, w1_sum}, {14'd0, tbl[n % 8].co, tbl[n % 8].s});
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
